cw_chaff_sched: RTL

//  Sequencer for the chaffing-and-winnowing datapath. Accepts one CWBITS-bit message and a counter base.
//  For each bit it fetches the authentic MAC tag from the MAC cache and emits two packets:
//   - wheat: the real bit with the real tag.
//   - chaff: the complemented bit with a pseudo-random tag.

---
 rtl/cw_pkg.sv | 27 ++
 rtl/cw_lfsr.sv | 34 +++
 rtl/cw_chaff_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cw_pkg.sv
// Shared types and constants for the chaffing-and-winnowing packet sequencer.
package cw_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EMIT0 = 3'd3,
    EMIT1 = 3'd4,
    DONE  = 3'd5
  } cw_state_e;

  // Default field widths of a {ctr, bit, tag} packet
  localparam int unsigned CW_TAGSIZE = 16;
  localparam int unsigned CW_CTRSIZE = 16;
  localparam int unsigned CW_PKT_W   = CW_CTRSIZE + CW_TAGSIZE + 1;

  // Packet field offsets
  localparam int unsigned TAG_LSB = 0;
  localparam int unsigned BIT_POS = CW_TAGSIZE;
  localparam int unsigned CTR_LSB = CW_TAGSIZE + 1;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/cw_lfsr.sv
// Galois LFSR producing pseudo-random chaff tags; advances only when step_i is high.
module cw_lfsr #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(0)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Next value: shift right, fold taps in when the outgoing bit is 1
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : WIDTH'(0));
    end
  end

  // State register, reloads the seed on reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/cw_chaff_sched.sv
// Chaffing-and-winnowing sequencer: for each message bit fetch the MAC tag,
// then emit a wheat packet (real bit, real tag) and a chaff packet
// (complemented bit, LFSR tag that never equals the real one).
// Optional build macro: CW_SHUFFLE_EN randomises the wheat/chaff order per bit.
module cw_chaff_sched
  import cw_pkg::*;
#(
  parameter int unsigned CWBITS    = 32,
  parameter int unsigned CTRSIZE   = 16,
  parameter int unsigned TAGSIZE   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [CWBITS-1:0]          msg_data,
  input  logic [CTRSIZE-1:0]         msg_ctr_base,
  output logic                       mac_req_vld,
  input  logic                       mac_req_rdy,
  output logic [CTRSIZE-1:0]         mac_req_ctr,
  output logic                       mac_req_bit,
  input  logic                       mac_rsp_vld,
  input  logic [TAGSIZE-1:0]         mac_rsp_tag,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [CTRSIZE+TAGSIZE:0]   pkt_data,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IDXW = (CWBITS > 1) ? $clog2(CWBITS) : 1;
  localparam int unsigned PKTW = CTRSIZE + TAGSIZE + 1;

  cw_state_e           state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [CWBITS-1:0]   msg_q, msg_d;
  logic [CTRSIZE-1:0]  base_q, base_d;
  logic [TAGSIZE-1:0]  tag_q, tag_d;
  logic                chaff_first_q, chaff_first_d;

  logic                msg_ready_q, msg_ready_d;
  logic                busy_q, busy_d;
  logic                mac_req_vld_q, mac_req_vld_d;
  logic [CTRSIZE-1:0]  mac_req_ctr_q, mac_req_ctr_d;
  logic                mac_req_bit_q, mac_req_bit_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic [PKTW-1:0]     pkt_data_q, pkt_data_d;
  logic                done_q, done_d;

  logic [TAGSIZE-1:0]  lfsr_val;
  logic                lfsr_step_c;
  logic [CTRSIZE-1:0]  cur_ctr;
  logic                cur_bit;

  // Chaff tag is the LFSR value, nudged off the wheat tag if they collide
  function automatic logic [TAGSIZE-1:0] chaff_tag_f(input logic [TAGSIZE-1:0] lv,
                                                      input logic [TAGSIZE-1:0] wheat);
    chaff_tag_f = (lv == wheat) ? (lv ^ TAGSIZE'(1)) : lv;
  endfunction

  function automatic logic [PKTW-1:0] pkt_f(input logic [CTRSIZE-1:0] c,
                                            input logic               b,
                                            input logic [TAGSIZE-1:0] t);
    pkt_f = {c, b, t};
  endfunction

  cw_lfsr #(
    .WIDTH (TAGSIZE),
    .SEED  (TAGSIZE'(LFSR_SEED)),
    .TAPS  (TAGSIZE'(LFSR_TAPS))
  ) u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .step_i  (lfsr_step_c),
    .value_o (lfsr_val)
  );

  // Counter and bit of the bit currently being processed (counter wraps)
  assign cur_ctr = base_q + CTRSIZE'(idx_q);
  assign cur_bit = msg_q[idx_q];

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    msg_d         = msg_q;
    base_d        = base_q;
    tag_d         = tag_q;
    chaff_first_d = chaff_first_q;
    pkt_data_d    = pkt_data_q;
    lfsr_step_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (msg_valid) begin
          msg_d   = msg_data;
          base_d  = msg_ctr_base;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mac_req_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mac_rsp_vld) begin
          tag_d = mac_rsp_tag;
`ifdef CW_SHUFFLE_EN
          chaff_first_d = lfsr_val[1];
`else
          chaff_first_d = 1'b0;
`endif
          pkt_data_d = chaff_first_d
                     ? pkt_f(cur_ctr, ~cur_bit, chaff_tag_f(lfsr_val, mac_rsp_tag))
                     : pkt_f(cur_ctr, cur_bit, mac_rsp_tag);
          state_d = EMIT0;
        end
      end
      EMIT0: begin
        if (pkt_ready) begin
          lfsr_step_c = chaff_first_q;
          pkt_data_d  = chaff_first_q
                      ? pkt_f(cur_ctr, cur_bit, tag_q)
                      : pkt_f(cur_ctr, ~cur_bit, chaff_tag_f(lfsr_val, tag_q));
          state_d = EMIT1;
        end
      end
      EMIT1: begin
        if (pkt_ready) begin
          lfsr_step_c = ~chaff_first_q;
          if (idx_q == IDXW'(CWBITS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are valid from its first cycle
    msg_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    mac_req_vld_d = (state_d == FETCH);
    pkt_valid_d   = (state_d == EMIT0) || (state_d == EMIT1);
    done_d        = (state_d == DONE);
    mac_req_ctr_d = mac_req_vld_d ? (base_d + CTRSIZE'(idx_d)) : '0;
    mac_req_bit_d = mac_req_vld_d ? msg_d[idx_d] : 1'b0;
    if (!pkt_valid_d) begin
      pkt_data_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      msg_q         <= '0;
      base_q        <= '0;
      tag_q         <= '0;
      chaff_first_q <= 1'b0;
      msg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      mac_req_vld_q <= 1'b0;
      mac_req_ctr_q <= '0;
      mac_req_bit_q <= 1'b0;
      pkt_valid_q   <= 1'b0;
      pkt_data_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      msg_q         <= msg_d;
      base_q        <= base_d;
      tag_q         <= tag_d;
      chaff_first_q <= chaff_first_d;
      msg_ready_q   <= msg_ready_d;
      busy_q        <= busy_d;
      mac_req_vld_q <= mac_req_vld_d;
      mac_req_ctr_q <= mac_req_ctr_d;
      mac_req_bit_q <= mac_req_bit_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_data_q    <= pkt_data_d;
      done_q        <= done_d;
    end
  end

  assign msg_ready   = msg_ready_q;
  assign busy        = busy_q;
  assign mac_req_vld = mac_req_vld_q;
  assign mac_req_ctr = mac_req_ctr_q;
  assign mac_req_bit = mac_req_bit_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_data    = pkt_data_q;
  assign done        = done_q;

endmodule
